// File: rtl/bfly_pkg.sv
// bfly_pkg: shared types and constants for the butterfly switch ingress path.
//   flit_type_e   : 2-bit flit type (IDLE/HEAD/BODY/TAIL)
//   flit_t        : packed flit {type, payload}; head payload[DEST_W-1:0] = destination port
//   IDLE_FLIT     : all-zero idle flit driven when nothing is sent
//   frame_state_e : ingress framing FSM states
package bfly_pkg;

    localparam int unsigned FLIT_W    = 18;
    localparam int unsigned TYPE_W    = 2;
    localparam int unsigned PAYLOAD_W = 16;
    localparam int unsigned DEST_W    = 6;

    typedef enum logic [TYPE_W-1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        BODY = 2'b10,
        TAIL = 2'b11
    } flit_type_e;

    typedef struct packed {
        flit_type_e             ftype;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    localparam flit_t IDLE_FLIT = '{ftype: IDLE, payload: '0};

    typedef enum logic {
        EXPECT_HEAD = 1'b0,
        IN_PKT      = 1'b1
    } frame_state_e;

endpackage

// File: rtl/bfly_fifo.sv
// bfly_fifo: synchronous FIFO with wrap-bit pointers and registered full/empty flags.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write strobe and data (caller must not push when full)
//   pop        : read strobe (caller must not pop when empty)
//   rdata_c    : combinational head-of-queue data
//   full/empty : registered status flags
module bfly_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [PW-1:0]    wptr_nxt, rptr_nxt;

    assign wptr_nxt = wptr + PW'(push);
    assign rptr_nxt = rptr + PW'(pop);
    assign rdata_c  = mem[rptr[AW-1:0]];

    // Pointers and flags; flags derived from next pointers so they stay in step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            full  <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                     (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
            empty <= (wptr_nxt == rptr_nxt);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/bfly_inject_buf.sv
// bfly_inject_buf: per-port ingress buffer in front of one butterfly switch lane.
// Checks packet framing, buffers legal flits, and forwards them under credit flow control.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in_valid/in_flit/in_ready : endpoint valid/ready flit interface
//   credit_in  : one-cycle pulse, one downstream slot freed
//   out_ch     : registered flit to switch lane (idle when nothing sent)
//   proto_err  : sticky framing violation
//   cred_err   : sticky credit overflow
//   pkt_cnt    : transmitted tails; counts only when BFLY_INJ_STATS_EN is defined, else 0
module bfly_inject_buf
    import bfly_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = 18,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned CREDITS       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [CHANNEL_WIDTH-1:0] in_flit,
    output logic                     in_ready,
    input  logic                     credit_in,
    output logic [CHANNEL_WIDTH-1:0] out_ch,
    output logic                     proto_err,
    output logic                     cred_err,
    output logic [15:0]              pkt_cnt
);

    localparam int unsigned       CRED_W   = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    flit_t             in_f;
    flit_t             fifo_rdata;
    frame_state_e      state, state_nxt;
    logic              accept, store, frame_err, push, send;
    logic              fifo_full, fifo_empty;
    logic [CRED_W-1:0] credit;

    assign in_f     = flit_t'(FLIT_W'(in_flit));
    assign in_ready = ~fifo_full;
    assign accept   = in_valid & in_ready;
    assign push     = accept & store;
    assign send     = ~fifo_empty & (credit != '0);

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EXPECT_HEAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Framing next-state: decide store vs drop for each accepted flit.
    always_comb begin
        state_nxt = state;
        store     = 1'b0;
        frame_err = 1'b0;
        if (accept) begin
            unique case (in_f.ftype)
                IDLE: ;
                HEAD: begin
                    if (state == EXPECT_HEAD) begin
                        store     = 1'b1;
                        state_nxt = IN_PKT;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                BODY: begin
                    if (state == IN_PKT) begin
                        store = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                TAIL: begin
                    if (state == IN_PKT) begin
                        store     = 1'b1;
                        state_nxt = EXPECT_HEAD;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    bfly_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wdata   (in_f),
        .pop     (send),
        .rdata_c (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Lane output register and sticky framing error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ch    <= '0;
            proto_err <= 1'b0;
        end else begin
            out_ch    <= send ? CHANNEL_WIDTH'(fifo_rdata) : CHANNEL_WIDTH'(IDLE_FLIT);
            proto_err <= proto_err | frame_err;
        end
    end

    // Credit counter; a return at full credit is flagged and ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit   <= CRED_MAX;
            cred_err <= 1'b0;
        end else begin
            unique case ({send, credit_in})
                2'b10: credit <= credit - CRED_W'(1);
                2'b01: begin
                    if (credit == CRED_MAX) begin
                        cred_err <= 1'b1;
                    end else begin
                        credit <= credit + CRED_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BFLY_INJ_STATS_EN
    logic [15:0] pkt_q;

    // Transmitted-tail counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
        end else if (send && (fifo_rdata.ftype == TAIL)) begin
            pkt_q <= pkt_q + 16'd1;
        end
    end

    assign pkt_cnt = pkt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_bfly_inject_buf.sv
module tb_bfly_inject_buf;

    localparam int DEPTH   = 8;
    localparam int CREDITS = 4;
`ifdef BFLY_INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [17:0] in_flit;
    logic        in_ready;
    logic        credit_in;
    logic [17:0] out_ch;
    logic        proto_err;
    logic        cred_err;
    logic [15:0] pkt_cnt;

    bfly_inject_buf #(
        .CHANNEL_WIDTH (18),
        .DEPTH         (DEPTH),
        .CREDITS       (CREDITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .credit_in (credit_in),
        .out_ch    (out_ch),
        .proto_err (proto_err),
        .cred_err  (cred_err),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: queue of stored flits plus counters.
    logic [17:0] mq[$];
    int          m_cred;
    bit          m_inpkt, m_perr, m_cerr;
    logic [17:0] m_out;
    logic [15:0] m_pkts;

    function automatic logic [36:0] model_vec();
        logic [15:0] p;
        p = STATS ? m_pkts : 16'd0;
        return {m_out, (mq.size() < DEPTH), m_perr, m_cerr, p};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {out_ch, in_ready, proto_err, cred_err, pkt_cnt};
    endfunction

    function automatic logic [17:0] mk(input logic [1:0] t, input logic [15:0] p);
        return {t, p};
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_flit   = '0;
        credit_in = 1'b0;
        mq.delete();
        m_cred  = CREDITS;
        m_inpkt = 1'b0;
        m_perr  = 1'b0;
        m_cerr  = 1'b0;
        m_out   = '0;
        m_pkts  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, advance the model by its rules, then step past the edge.
    task automatic tick(input bit v, input logic [17:0] f, input bit c);
        bit acc, send;
        in_valid  = v;
        in_flit   = f;
        credit_in = c;
        acc  = v && (mq.size() < DEPTH);
        send = (mq.size() != 0) && (m_cred > 0);
        if (send) begin
            m_out = mq.pop_front();
            if (m_out[17:16] == 2'b11) m_pkts = m_pkts + 16'd1;
        end else begin
            m_out = '0;
        end
        if (acc) begin
            case (f[17:16])
                2'b01: if (!m_inpkt) begin mq.push_back(f); m_inpkt = 1'b1; end else m_perr = 1'b1;
                2'b10: if (m_inpkt) mq.push_back(f); else m_perr = 1'b1;
                2'b11: if (m_inpkt) begin mq.push_back(f); m_inpkt = 1'b0; end else m_perr = 1'b1;
                default: ;
            endcase
        end
        if (send && !c) m_cred--;
        else if (c && !send) begin
            if (m_cred == CREDITS) m_cerr = 1'b1;
            else m_cred++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_ch !== 18'h0) begin errors++; $display("FAIL reset_out_ch got %h want 0", out_ch); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
        checks++; if (cred_err !== 1'b0) begin errors++; $display("FAIL reset_cred_err got %b want 0", cred_err); end
        checks++; if (pkt_cnt !== 16'h0) begin errors++; $display("FAIL reset_pkt_cnt got %h want 0", pkt_cnt); end
    endtask

    task automatic test_basic_packet();
        logic [17:0] stim [5];
        logic [17:0] expv [5];
        do_reset();
        stim = '{mk(2'b01, 16'h002A), mk(2'b10, 16'h1234), mk(2'b11, 16'h5678), 18'h0, 18'h0};
        expv = '{18'h0, mk(2'b01, 16'h002A), mk(2'b10, 16'h1234), mk(2'b11, 16'h5678), 18'h0};
        for (int i = 0; i < 5; i++) begin
            tick(i < 3, stim[i], 1'b0);
            checks++;
            if (out_ch !== expv[i]) begin errors++; $display("FAIL basic_out_ch[%0d] got %h want %h", i, out_ch, expv[i]); end
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL basic_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (pkt_cnt !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL basic_pkt_cnt got %0d", pkt_cnt); end
    endtask

    task automatic test_credit_stall();
        int sent, first, last;
        logic [17:0] f;
        do_reset();
        sent = 0;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) f = mk(2'b01, 16'($urandom_range(0, 63)));
            else if (i < 7) f = mk(2'b10, 16'($urandom));
            else f = mk(2'b11, 16'($urandom));
            tick(i < 8, f, 1'b0);
            if (out_ch !== 18'h0) sent++;
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL stall_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (sent !== 4) begin errors++; $display("FAIL stall_sent got %0d want 4", sent); end
        sent = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 18'h0, i < 4);
            if (out_ch !== 18'h0) begin sent++; if (first < 0) first = i; last = i; end
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL resume_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (sent !== 4 || (last - first) !== 3) begin
            errors++; $display("FAIL resume_b2b got sent=%0d span=%0d want sent=4 span=3", sent, last - first);
        end
    endtask

    task automatic test_full();
        int acc;
        do_reset();
        tick(1'b1, mk(2'b01, 16'h0005), 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, mk(2'b10, 16'(i)), 1'b0);
        repeat (3) tick(1'b0, 18'h0, 1'b0);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (in_ready) acc++;
            tick(1'b1, mk(2'b10, 16'(16'h100 + i)), 1'b0);
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL full_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (acc !== 8) begin errors++; $display("FAIL full_accepts got %0d want 8", acc); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        tick(1'b1, mk(2'b10, 16'h0200), 1'b1);
        tick(1'b1, mk(2'b10, 16'h0200), 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL pop_in_ready got %b want 1", in_ready); end
        tick(1'b1, mk(2'b10, 16'h0200), 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL refill_in_ready got %b want 0", in_ready); end
        checks++;
        if (dut_vec() !== model_vec()) begin errors++; $display("FAIL refill_model got %h want %h", dut_vec(), model_vec()); end
    endtask

    task automatic test_proto_err();
        logic [17:0] bad_b, bad_h;
        logic [17:0] seq [10];
        int sent, leaks;
        do_reset();
        bad_b = mk(2'b10, 16'hBAD1);
        bad_h = mk(2'b01, 16'hBAD2);
        seq = '{bad_b, mk(2'b01, 16'h0011), mk(2'b10, 16'h2222), bad_h, mk(2'b11, 16'h3333),
                18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
        sent = 0; leaks = 0;
        for (int i = 0; i < 10; i++) begin
            tick(i < 5, seq[i], 1'b0);
            if (i == 0) begin
                checks++;
                if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_body_first got %b want 1", proto_err); end
            end
            if (out_ch === bad_b || out_ch === bad_h) leaks++;
            if (out_ch !== 18'h0) sent++;
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL proto_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (leaks !== 0 || sent !== 3) begin errors++; $display("FAIL proto_drop got leaks=%0d sent=%0d want 0/3", leaks, sent); end
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", proto_err); end
    endtask

    task automatic test_cred_err();
        int sent;
        do_reset();
        tick(1'b0, 18'h0, 1'b1);
        checks++;
        if (cred_err !== 1'b1) begin errors++; $display("FAIL cred_err_set got %b want 1", cred_err); end
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            tick(i < 6, (i == 0) ? mk(2'b01, 16'h0001) : mk((i == 5) ? 2'b11 : 2'b10, 16'(i)), 1'b0);
            if (out_ch !== 18'h0) sent++;
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL cred_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (sent !== 4) begin errors++; $display("FAIL cred_hold got sent=%0d want 4", sent); end
        do_reset();
        sent = 0;
        for (int i = 0; i < 12; i++) begin
            tick(i < 6, (i == 0) ? mk(2'b01, 16'h0002) : mk((i == 5) ? 2'b11 : 2'b10, 16'(i)), i == 1);
            if (out_ch !== 18'h0) sent++;
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL cred_sim_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
        checks++;
        if (sent !== 5 || cred_err !== 1'b0) begin errors++; $display("FAIL cred_simultaneous got sent=%0d cred_err=%b want 5/0", sent, cred_err); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < 12; i++) tick(i < 8, (i == 0) ? mk(2'b01, 16'h0007) : mk(2'b10, 16'(16'h40 + i)), 1'b0);
        tick(1'b0, 18'h0, 1'b1);
        tick(1'b0, 18'h0, 1'b0);
        checks++;
        if (out_ch !== mk(2'b10, 16'h44)) begin errors++; $display("FAIL midpkt_out got %h want %h", out_ch, mk(2'b10, 16'h44)); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_ch !== 18'h0) begin errors++; $display("FAIL async_reset_out got %h want 0", out_ch); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b want 1", in_ready); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 18'h0, 1'b0);
            checks++;
            if (out_ch !== 18'h0) begin errors++; $display("FAIL flushed_out[%0d] got %h want 0", i, out_ch); end
        end
        tick(1'b1, mk(2'b10, 16'h0099), 1'b0);
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL post_reset_body got %b want 1", proto_err); end
        tick(1'b0, 18'h0, 1'b0);
        checks++;
        if (out_ch !== 18'h0 || dut_vec() !== model_vec()) begin errors++; $display("FAIL post_reset_model got %h want %h", dut_vec(), model_vec()); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) != 0,
                 mk(2'($urandom_range(0, 3)), 16'($urandom)),
                 $urandom_range(0, 3) == 0);
            checks++;
            if (dut_vec() !== model_vec()) begin errors++; $display("FAIL random_model cyc %0d got %h want %h", cyc, dut_vec(), model_vec()); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_credit_stall();
        test_full();
        test_proto_err();
        test_cred_err();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
